// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with blanking gap and leading-zero suppression
module seg_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*NDIG-1:0]   load_data,
  input  logic                lz_en,
  output logic [3:0]          dec_in,
  input  logic [6:0]          dec_out,
  output logic [NDIG-1:0]     an,
  output logic [6:0]          seg
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
  localparam logic [IW-1:0] I_LAST  = IW'(NDIG - 1);

  logic [PW-1:0]     p;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] disp;
  logic [4*NDIG-1:0] pend;
  logic              pend_full;
  logic [NDIG-1:0]   an_r;
  logic [6:0]        seg_r;
  logic [NDIG-1:0]   zero_from;
  logic              suppressed;
  logic              slot_end;
  logic              frame_end;
  logic              transfer;

  assign slot_end   = (p == P_LAST);
  assign frame_end  = slot_end && (idx == I_LAST);
  assign transfer   = load_valid && !pend_full;
  assign load_ready = ~pend_full;
  assign dec_in     = disp[{idx, 2'b00} +: 4];
  assign an         = an_r;
  assign seg        = seg_r;

  // zero_from[i] is set when nibble i and every nibble above it are zero
  always_comb begin
    zero_from = '0;
    zero_from[NDIG-1] = (disp[4*(NDIG-1) +: 4] == 4'h0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (disp[4*i +: 4] == 4'h0);
    end
    suppressed = lz_en && (idx != '0) && zero_from[idx];
  end

  // Slot prescaler and digit index; idx advances when the prescaler wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p   <= '0;
      idx <= '0;
    end else if (slot_end) begin
      p   <= '0;
      idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      p   <= p + 1'b1;
    end
  end

  // Pending buffer capture and commit into the displayed value at the frame boundary only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
      disp      <= '0;
    end else begin
      if (frame_end && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end
      if (transfer) begin
        pend      <= load_data;
        pend_full <= 1'b1;
      end
    end
  end

  // Registered anode/segment drive: blank during the gap or for suppressed digits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r  <= '1;
      seg_r <= 7'h7F;
    end else if ((p < P_BLANK) || suppressed) begin
      an_r  <= '1;
      seg_r <= 7'h7F;
    end else begin
      an_r  <= ~(NDIG'(1) << idx);
      seg_r <= ~dec_out;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  dec_in;
  logic [6:0]  dec_out;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       rdy;
  } exp_t;
  exp_t sb[$];

  int          c;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_full;
  logic        last_xfer;

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  assign dec_out = hex7(dec_in);

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .lz_en(lz_en), .dec_in(dec_in), .dec_out(dec_out),
    .an(an), .seg(seg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    logic [15:0] s;
    s = v >> (4 * i);
    return s[3:0];
  endfunction

  // One clock: predict from pre-edge state, push, advance model, pop and compare
  task automatic tick();
    exp_t e;
    int   ph;
    int   dg;
    logic blank;
    logic [15:0] upper;
    ph = c % DIV;
    dg = (c / DIV) % NDIG;
    upper = m_disp >> (4 * dg);
    blank = (ph < BLANK) || (lz_en && dg != 0 && upper == 16'h0);
    e.an  = blank ? 4'hF : ~(4'h1 << dg);
    e.seg = blank ? 7'h7F : ~hex7(nib(m_disp, dg));
    last_xfer = load_valid && !m_full;
    if ((c % FRAME) == FRAME - 1 && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (last_xfer) begin
      m_pend = load_data;
      m_full = 1'b1;
    end
    e.rdy = !m_full;
    sb.push_back(e);
    @(posedge clk);
    #1;
    c++;
    e = sb.pop_front();
    check("an", {28'h0, an}, {28'h0, e.an});
    check("seg", {25'h0, seg}, {25'h0, e.seg});
    check("load_ready", {31'h0, load_ready}, {31'h0, e.rdy});
    check("dec_in", {28'h0, dec_in}, {28'h0, nib(m_disp, (c / DIV) % NDIG)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a value and hold it until accepted, then drop valid and scramble data
  task automatic send(input logic [15:0] d);
    int k;
    load_valid = 1'b1;
    load_data  = d;
    k = 0;
    last_xfer = 1'b0;
    while (!last_xfer && k < 3 * FRAME) begin
      tick();
      k++;
    end
    if (!last_xfer) check("send_timeout", 32'h0, 32'h1);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while ((c % FRAME) != ph && k < 2 * FRAME) begin
      tick();
      k++;
    end
  endtask

  initial begin
    c = 0; m_disp = '0; m_pend = '0; m_full = 1'b0; last_xfer = 1'b0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_ready", {31'h0, load_ready}, 32'h1);
    check("rst_dec_in", {28'h0, dec_in}, 32'h0);
    reset = 1'b0;
    run(FRAME + 3);
    // 1234 loaded mid-frame, shown from the next frame
    send(16'h1234);
    run(2 * FRAME);
    // second value held while pending is full
    send(16'hABCD);
    send(16'h5678);
    run(2 * FRAME);
    // leading-zero suppression
    lz_en = 1'b1;
    send(16'h0050);
    run(2 * FRAME);
    lz_en = 1'b0;
    run(FRAME);
    // all-zero value with suppression on: only digit 0 lights
    lz_en = 1'b1;
    send(16'h0000);
    run(2 * FRAME);
    lz_en = 1'b0;
    // asynchronous reset at idx=2, p=5 with a pending value
    wait_phase(0);
    send(16'h9999);
    wait_phase(2 * DIV + 5);
    check("pre_rst_full", {31'h0, load_ready}, 32'h0);
    check("pre_rst_an", {28'h0, an}, 32'hB);
    #2;
    reset = 1'b1;
    #1;
    check("async_an", {28'h0, an}, 32'hF);
    check("async_seg", {25'h0, seg}, 32'h7F);
    check("async_ready", {31'h0, load_ready}, 32'h1);
    check("async_dec_in", {28'h0, dec_in}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    c = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;
    run(2 * FRAME);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
